// File: rtl/ascon_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// ascon_ctrl_fsm
//
// Control FSM for the ASCON-128 datapath. It owns the round counter and
// sequences initialisation, any number of associated-data blocks (including
// none), any number of plaintext blocks, finalisation and tag output.
// Data blocks are taken over a valid/ready handshake.
//
// Parameters:
//   ROUNDS_A  rounds of p^a for init/final (ROUNDS_B..12)
//   ROUNDS_B  rounds of p^b per data block (1..ROUNDS_A)
//   CNT_W     width of round_o (must hold 11)
//
// Ports:
//   clock_i           clock
//   resetb_i          asynchronous active-low reset
//   start_i           start an operation (sampled in IDLE only)
//   ad_empty_i        operation has no AD (sampled with start_i)
//   data_valid_i      data block present on datapath input
//   data_last_i       block is last of its phase (sampled on handshake)
//   ready_o           FSM accepts a block (WAIT_AD / WAIT_PT)
//   round_o           round-constant index, start value .. 11
//   data_select_o     0 = load IV||K||N, 1 = permutation output
//   en_reg_state_o    state register enable
//   en_xor_d_beg_o    XOR data into state before the round
//   en_xor_key_beg_o  XOR key before the round (finalisation)
//   en_xor_key_end_o  XOR key after the round
//   en_xor_lsb_end_o  domain-separation XOR of 1 into the LSB after the round
//   cipher_valid_o    ciphertext block valid (pulse)
//   busy_o            operation in progress
//   end_o             tag valid (pulse)
//
// Optional feature (macro ASCON_DECRYPT_EN):
//   decrypt_i         decrypt operation (sampled with start_i)
//   rate_replace_o    overwrite the rate with the ciphertext; then
//                     cipher_valid_o flags plaintext
// -----------------------------------------------------------------------------
module ascon_ctrl_fsm #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             ad_empty_i,
  input  logic             data_valid_i,
  input  logic             data_last_i,
`ifdef ASCON_DECRYPT_EN
  input  logic             decrypt_i,
  output logic             rate_replace_o,
`endif
  output logic             ready_o,
  output logic [CNT_W-1:0] round_o,
  output logic             data_select_o,
  output logic             en_reg_state_o,
  output logic             en_xor_d_beg_o,
  output logic             en_xor_key_beg_o,
  output logic             en_xor_key_end_o,
  output logic             en_xor_lsb_end_o,
  output logic             cipher_valid_o,
  output logic             busy_o,
  output logic             end_o
);

  localparam logic [CNT_W-1:0] RND_A_START = CNT_W'(12 - ROUNDS_A);
  localparam logic [CNT_W-1:0] RND_B_START = CNT_W'(12 - ROUNDS_B);
  localparam logic [CNT_W-1:0] RND_LAST    = CNT_W'(11);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT_LOAD = 4'd1,
    INIT_RND  = 4'd2,
    WAIT_AD   = 4'd3,
    AD_RND    = 4'd4,
    WAIT_PT   = 4'd5,
    PT_RND    = 4'd6,
    FIN_RND   = 4'd7,
    TAG       = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic             ad_empty_q, ad_empty_d;
  logic             last_q, last_d;
`ifdef ASCON_DECRYPT_EN
  logic             decrypt_q, decrypt_d;
  logic             rate_replace_q, rate_replace_d;
`endif

  // Registered outputs
  logic ready_q,        ready_d;
  logic data_select_q,  data_select_d;
  logic en_reg_state_q, en_reg_state_d;
  logic xor_d_beg_q,    xor_d_beg_d;
  logic xor_key_beg_q,  xor_key_beg_d;
  logic xor_key_end_q,  xor_key_end_d;
  logic xor_lsb_end_q,  xor_lsb_end_d;
  logic cipher_valid_q, cipher_valid_d;
  logic busy_q,         busy_d;
  logic end_q,          end_d;

  logic hs;
  logic rnd_done;

  assign hs       = data_valid_i & ready_q;
  assign rnd_done = (round_q == RND_LAST);

  // ---------------------------------------------------------------------------
  // Next-state, round counter and captured flags
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    ad_empty_d = ad_empty_q;
    last_d     = last_q;
`ifdef ASCON_DECRYPT_EN
    decrypt_d  = decrypt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = INIT_LOAD;
          ad_empty_d = ad_empty_i;
`ifdef ASCON_DECRYPT_EN
          decrypt_d  = decrypt_i;
`endif
        end
      end
      INIT_LOAD: begin
        state_d = INIT_RND;
        round_d = RND_A_START;
      end
      INIT_RND: begin
        if (rnd_done) begin
          state_d = ad_empty_q ? WAIT_PT : WAIT_AD;
        end else begin
          round_d = round_q + CNT_W'(1);
        end
      end
      WAIT_AD: begin
        if (hs) begin
          last_d  = data_last_i;
          state_d = AD_RND;
          round_d = RND_B_START;
        end
      end
      AD_RND: begin
        if (rnd_done) begin
          state_d = last_q ? WAIT_PT : WAIT_AD;
        end else begin
          round_d = round_q + CNT_W'(1);
        end
      end
      WAIT_PT: begin
        if (hs) begin
          last_d = data_last_i;
          if (data_last_i) begin
            state_d = FIN_RND;
            round_d = RND_A_START;
          end else begin
            state_d = PT_RND;
            round_d = RND_B_START;
          end
        end
      end
      PT_RND: begin
        if (rnd_done) begin
          state_d = WAIT_PT;
        end else begin
          round_d = round_q + CNT_W'(1);
        end
      end
      FIN_RND: begin
        if (rnd_done) begin
          state_d = TAG;
        end else begin
          round_d = round_q + CNT_W'(1);
        end
      end
      TAG: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so each registered output lines up
  // with the state/round it describes. "First cycle" of a RND phase is the
  // cycle where the counter holds its freshly loaded start value.
  // ---------------------------------------------------------------------------
  logic is_rnd_d;
  logic first_a_d;
  logic first_b_d;
  logic last_rnd_d;

  always_comb begin
    is_rnd_d   = (state_d == INIT_RND) || (state_d == AD_RND) ||
                 (state_d == PT_RND)   || (state_d == FIN_RND);
    first_a_d  = (round_d == RND_A_START);
    first_b_d  = (round_d == RND_B_START);
    last_rnd_d = (round_d == RND_LAST);

    ready_d        = (state_d == WAIT_AD) || (state_d == WAIT_PT);
    busy_d         = (state_d != IDLE);
    data_select_d  = (state_d != INIT_LOAD);
    en_reg_state_d = (state_d == INIT_LOAD) || is_rnd_d;

    xor_d_beg_d    = ((state_d == AD_RND)  && first_b_d) ||
                     ((state_d == PT_RND)  && first_b_d) ||
                     ((state_d == FIN_RND) && first_a_d);
    xor_key_beg_d  = (state_d == FIN_RND) && first_a_d;
    xor_key_end_d  = ((state_d == INIT_RND) || (state_d == FIN_RND)) && last_rnd_d;
    xor_lsb_end_d  = ((state_d == INIT_RND) && last_rnd_d && ad_empty_d) ||
                     ((state_d == AD_RND)   && last_rnd_d && last_d);
    cipher_valid_d = ((state_d == PT_RND)  && first_b_d) ||
                     ((state_d == FIN_RND) && first_a_d);
    end_d          = (state_d == TAG);
`ifdef ASCON_DECRYPT_EN
    rate_replace_d = decrypt_d && xor_d_beg_d &&
                     ((state_d == PT_RND) || (state_d == FIN_RND));
`endif
  end

  // ---------------------------------------------------------------------------
  // State, counter, flags and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= IDLE;
      round_q        <= '0;
      ad_empty_q     <= 1'b0;
      last_q         <= 1'b0;
`ifdef ASCON_DECRYPT_EN
      decrypt_q      <= 1'b0;
      rate_replace_q <= 1'b0;
`endif
      ready_q        <= 1'b0;
      data_select_q  <= 1'b0;
      en_reg_state_q <= 1'b0;
      xor_d_beg_q    <= 1'b0;
      xor_key_beg_q  <= 1'b0;
      xor_key_end_q  <= 1'b0;
      xor_lsb_end_q  <= 1'b0;
      cipher_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      end_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      ad_empty_q     <= ad_empty_d;
      last_q         <= last_d;
`ifdef ASCON_DECRYPT_EN
      decrypt_q      <= decrypt_d;
      rate_replace_q <= rate_replace_d;
`endif
      ready_q        <= ready_d;
      data_select_q  <= data_select_d;
      en_reg_state_q <= en_reg_state_d;
      xor_d_beg_q    <= xor_d_beg_d;
      xor_key_beg_q  <= xor_key_beg_d;
      xor_key_end_q  <= xor_key_end_d;
      xor_lsb_end_q  <= xor_lsb_end_d;
      cipher_valid_q <= cipher_valid_d;
      busy_q         <= busy_d;
      end_q          <= end_d;
    end
  end

  assign ready_o          = ready_q;
  assign round_o          = round_q;
  assign data_select_o    = data_select_q;
  assign en_reg_state_o   = en_reg_state_q;
  assign en_xor_d_beg_o   = xor_d_beg_q;
  assign en_xor_key_beg_o = xor_key_beg_q;
  assign en_xor_key_end_o = xor_key_end_q;
  assign en_xor_lsb_end_o = xor_lsb_end_q;
  assign cipher_valid_o   = cipher_valid_q;
  assign busy_o           = busy_q;
  assign end_o            = end_q;
`ifdef ASCON_DECRYPT_EN
  assign rate_replace_o   = rate_replace_q;
`endif

endmodule
